// File: rtl/spu_regfile_mp.sv
// spu_regfile_mp: parametrised multi-port register file with sequenced clear and streamed load
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i         per-port write enable (NUM_WR)
//   wr_addr_i       write addresses, port j in slice j
//   wr_data_i       write data, port j in slice j
//   rd_addr_i       read addresses, port i in slice i
//   rd_data_o       combinational read data, port i in slice i
//   init_start_i    request a streamed load of all DEPTH entries
//   init_valid_i    init_data_i valid
//   init_data_i     load beat data
//   init_ready_o    load beat accepted when high together with init_valid_i
//   init_done_o     one-cycle pulse after the last load beat
//   rf_ready_o      array usable by write/read ports
//   wr_conflict_o   pulse: two or more enabled write ports hit the same address
module spu_regfile_mp #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int NUM_RD = 6,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    input  logic                       init_start_i,
    input  logic                       init_valid_i,
    input  logic [DATA_W-1:0]          init_data_i,
    output logic                       init_ready_o,
    output logic                       init_done_o,
    output logic                       rf_ready_o,
    output logic                       wr_conflict_o
);
    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rf_ready_q, rf_ready_d;
    logic              init_ready_q, init_ready_d;
    logic              init_done_q, init_done_d;
    logic              conflict_q, conflict_d;
    logic              conflict;
    logic              last;
    logic              beat;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign last = cnt_q == (ADDR_W+1)'(DEPTH-1);
    assign idx  = cnt_q[ADDR_W-1:0];
    // init_ready_q is only ever high in LOAD, so this alone qualifies a load beat
    assign beat = init_valid_i & init_ready_q;

    assign rf_ready_o    = rf_ready_q;
    assign init_ready_o  = init_ready_q;
    assign init_done_o   = init_done_q;
    assign wr_conflict_o = conflict_q;

    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++)
            for (int k = j + 1; k < NUM_WR; k++)
                if (wr_en_i[j] && wr_en_i[k] &&
                    wr_addr_i[j*ADDR_W +: ADDR_W] == wr_addr_i[k*ADDR_W +: ADDR_W])
                    conflict = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rf_ready_d   = rf_ready_q;
        init_ready_d = init_ready_q;
        init_done_d  = 1'b0;
        conflict_d   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d    = S_IDLE;
                    rf_ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                conflict_d = conflict;
                if (init_start_i) begin
                    state_d      = S_LOAD;
                    cnt_d        = '0;
                    rf_ready_d   = 1'b0;
                    init_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d      = S_IDLE;
                        init_ready_d = 1'b0;
                        rf_ready_d   = 1'b1;
                        init_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            rf_ready_q   <= 1'b0;
            init_ready_q <= 1'b0;
            init_done_q  <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rf_ready_q   <= rf_ready_d;
            init_ready_q <= init_ready_d;
            init_done_q  <= init_done_d;
            conflict_q   <= conflict_d;
        end
    end

    // Array has no reset of its own; the reset edge leaves contents alone and CLEAR zeroes them.
    // Ascending port order makes the highest-index write port win on a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR)
                mem_q[idx] <= '0;
            else if (state_q == S_LOAD && beat)
                mem_q[idx] <= init_data_i;
            else if (state_q == S_IDLE)
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_en_i[j])
                        mem_q[wr_addr_i[j*ADDR_W +: ADDR_W]] <= wr_data_i[j*DATA_W +: DATA_W];
        end
    end

    // Bypass only in IDLE, the only state where the write ports take effect
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_o[i*DATA_W +: DATA_W] = mem_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
            if (BYPASS != 0 && state_q == S_IDLE)
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_en_i[j] && wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i[i*ADDR_W +: ADDR_W])
                        rd_data_o[i*DATA_W +: DATA_W] = wr_data_i[j*DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_spu_regfile_mp.sv
// tb_spu_regfile_mp: self-checking bench for spu_regfile_mp (default config plus a reduced BYPASS=0 config)
module tb_spu_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [1:0]   wr_en = '0;
    logic [13:0]  wr_addr = '0;
    logic [255:0] wr_data = '0;
    logic [41:0]  rd_addr = '0;
    logic [767:0] rd_data;
    logic         init_start = 1'b0, init_valid = 1'b0;
    logic [127:0] init_data = '0;
    logic         init_ready, init_done, rf_ready, wr_conflict;

    logic [2:0]   s_wr_en = '0;
    logic [11:0]  s_wr_addr = '0;
    logic [95:0]  s_wr_data = '0;
    logic [11:0]  s_rd_addr = '0;
    logic [95:0]  s_rd_data;
    logic         s_init_start = 1'b0, s_init_valid = 1'b0;
    logic [31:0]  s_init_data = '0;
    logic         s_init_ready, s_init_done, s_rf_ready, s_wr_conflict;

    spu_regfile_mp dut (
        .clk(clk), .rst(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .init_start_i(init_start), .init_valid_i(init_valid), .init_data_i(init_data),
        .init_ready_o(init_ready), .init_done_o(init_done),
        .rf_ready_o(rf_ready), .wr_conflict_o(wr_conflict)
    );

    spu_regfile_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .NUM_RD(3), .NUM_WR(3), .BYPASS(0)) dut_s (
        .clk(clk), .rst(rst),
        .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
        .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data),
        .init_start_i(s_init_start), .init_valid_i(s_init_valid), .init_data_i(s_init_data),
        .init_ready_o(s_init_ready), .init_done_o(s_init_done),
        .rf_ready_o(s_rf_ready), .wr_conflict_o(s_wr_conflict)
    );

    typedef struct {
        string        name;
        logic [127:0] val;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    logic [127:0] ref_mem [128];
    int           errors = 0;
    int           checks = 0;

    function automatic void push(string n, logic [127:0] v);
        exp_q.push_back('{name: n, val: v});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n, ns;
        int sel[3] = '{0, 64, 127};
        logic [6:0] a;
        rst = 1'b1;
        repeat (3) tick();
        push("rst_outputs", 128'h0);
        push("rst_outputs_small", 128'h0);
        e = exp_q.pop_front(); checks++;
        if ({rf_ready, init_ready, init_done, wr_conflict} !== e.val[3:0]) begin
            errors++; $display("FAIL %s got=%b exp=%b", e.name, {rf_ready, init_ready, init_done, wr_conflict}, e.val[3:0]);
        end
        e = exp_q.pop_front(); checks++;
        if ({s_rf_ready, s_init_ready, s_init_done, s_wr_conflict} !== e.val[3:0]) begin
            errors++; $display("FAIL %s got=%b exp=%b", e.name, {s_rf_ready, s_init_ready, s_init_done, s_wr_conflict}, e.val[3:0]);
        end
        rst = 1'b0;
        n = 0; ns = 0;
        while (rf_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (s_rf_ready === 1'b1 && ns == 0) ns = n;
        end
        push("clear_cycles", 128'd128);
        push("small_clear_cycles", 128'd16);
        e = exp_q.pop_front(); checks++;
        if (128'(n) !== e.val) begin errors++; $display("FAIL %s got=%0d exp=%0d", e.name, n, e.val); end
        e = exp_q.pop_front(); checks++;
        if (128'(ns) !== e.val) begin errors++; $display("FAIL %s got=%0d exp=%0d", e.name, ns, e.val); end
        for (int k = 0; k < 128; k++) ref_mem[k] = '0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                a = 7'(sel[(i + r) % 3]);
                rd_addr[i*7 +: 7] = a;
                push($sformatf("clear_rd%0d_a%0d", i, a), ref_mem[a]);
            end
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); checks++;
                if (rd_data[i*128 +: 128] !== e.val) begin
                    errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[i*128 +: 128], e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_ports();
        logic [127:0] va, vb;
        va = {4{32'hAAAA_0001}};
        vb = {4{32'hBBBB_0002}};
        wr_en = 2'b11; wr_addr = {7'd5, 7'd5}; wr_data = {vb, va};
        rd_addr = '0; rd_addr[6:0] = 7'd5; rd_addr[13:7] = 7'd6;
        push("collide_bypass_p0", vb);
        push("collide_other_p1", ref_mem[6]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd_data[127:0] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[127:0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_data[255:128] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[255:128], e.val); end
        tick();
        wr_en = 2'b00;
        ref_mem[5] = vb;
        push("collide_conflict_hi", 128'd1);
        push("collide_array5", ref_mem[5]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (128'(wr_conflict) !== e.val) begin errors++; $display("FAIL %s got=%b exp=%0d", e.name, wr_conflict, e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_data[127:0] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[127:0], e.val); end
        tick();
        push("collide_conflict_lo", 128'd0);
        e = exp_q.pop_front(); checks++;
        if (128'(wr_conflict) !== e.val) begin errors++; $display("FAIL %s got=%b exp=%0d", e.name, wr_conflict, e.val); end
        wr_en = 2'b11; wr_addr = {7'd10, 7'd9}; wr_data = {128'hD0D0, 128'hC0C0};
        rd_addr[6:0] = 7'd10; rd_addr[13:7] = 7'd9; rd_addr[20:14] = 7'd11;
        push("split_p0", 128'hD0D0);
        push("split_p1", 128'hC0C0);
        push("split_p2", ref_mem[11]);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front(); checks++;
            if (rd_data[i*128 +: 128] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[i*128 +: 128], e.val); end
        end
        tick();
        ref_mem[9] = 128'hC0C0; ref_mem[10] = 128'hD0D0;
        wr_en = 2'b01; wr_addr = {7'd12, 7'd12}; wr_data = {128'hF1F1, 128'hE1E1};
        rd_addr[6:0] = 7'd12;
        push("split_conflict_lo", 128'd0);
        push("disabled_port_bypass", 128'hE1E1);
        e = exp_q.pop_front(); checks++;
        if (128'(wr_conflict) !== e.val) begin errors++; $display("FAIL %s got=%b exp=%0d", e.name, wr_conflict, e.val); end
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd_data[127:0] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[127:0], e.val); end
        tick();
        wr_en = 2'b00;
        ref_mem[12] = 128'hE1E1;
        push("disabled_port_conflict", 128'd0);
        push("disabled_port_array", ref_mem[12]);
        e = exp_q.pop_front(); checks++;
        if (128'(wr_conflict) !== e.val) begin errors++; $display("FAIL %s got=%b exp=%0d", e.name, wr_conflict, e.val); end
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd_data[127:0] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[127:0], e.val); end
        tick();
    endtask

    task automatic test_small_nobypass();
        s_wr_en = 3'b001; s_wr_addr = '0; s_wr_addr[3:0] = 4'd3; s_wr_data = '0; s_wr_data[31:0] = 32'hDEAD;
        s_rd_addr = '0; s_rd_addr[3:0] = 4'd3;
        push("nb_same_cycle_old", 128'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (128'(s_rd_data[31:0]) !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, s_rd_data[31:0], e.val); end
        tick();
        s_wr_en = 3'b000;
        push("nb_next_cycle_new", 128'hDEAD);
        #1;
        e = exp_q.pop_front(); checks++;
        if (128'(s_rd_data[31:0]) !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, s_rd_data[31:0], e.val); end
        tick();
        s_wr_en = 3'b101; s_wr_addr = {4'd15, 4'd15, 4'd15};
        s_wr_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        s_rd_addr[3:0] = 4'd15;
        push("small_collide_no_bypass", 128'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (128'(s_rd_data[31:0]) !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, s_rd_data[31:0], e.val); end
        tick();
        s_wr_en = 3'b000;
        push("small_conflict_hi", 128'd1);
        push("small_port2_wins", 128'h3333_3333);
        e = exp_q.pop_front(); checks++;
        if (128'(s_wr_conflict) !== e.val) begin errors++; $display("FAIL %s got=%b exp=%0d", e.name, s_wr_conflict, e.val); end
        #1;
        e = exp_q.pop_front(); checks++;
        if (128'(s_rd_data[31:0]) !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, s_rd_data[31:0], e.val); end
        tick();
        push("small_conflict_lo", 128'd0);
        e = exp_q.pop_front(); checks++;
        if (128'(s_wr_conflict) !== e.val) begin errors++; $display("FAIL %s got=%b exp=%0d", e.name, s_wr_conflict, e.val); end
    endtask

    task automatic test_load();
        int k, c, pulses;
        logic [6:0] a;
        wr_en = 2'b01; wr_addr = {7'd0, 7'd7}; wr_data = {128'h0, 128'h77};
        init_start = 1'b1;
        tick();
        init_start = 1'b0; wr_en = 2'b00;
        rd_addr = '0; rd_addr[6:0] = 7'd7;
        push("load_entry_flags", 128'b010);
        push("load_start_write_done", 128'h77);
        e = exp_q.pop_front(); checks++;
        if ({rf_ready, init_ready, init_done} !== e.val[2:0]) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, {rf_ready, init_ready, init_done}, e.val[2:0]); end
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd_data[127:0] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[127:0], e.val); end
        k = 0; c = 0; pulses = 0;
        while (k < 128 && c < 400) begin
            init_valid = (c % 3 != 2);
            init_data = 128'(k);
            wr_en = 2'b11;
            wr_addr = {7'($urandom), 7'($urandom)};
            wr_data = {2{128'h0BAD}};
            tick();
            if (init_valid) k++;
            if (init_done === 1'b1) pulses++;
            c++;
        end
        push("load_exit_flags", 128'b101);
        e = exp_q.pop_front(); checks++;
        if ({rf_ready, init_ready, init_done} !== e.val[2:0]) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, {rf_ready, init_ready, init_done}, e.val[2:0]); end
        init_valid = 1'b0; wr_en = 2'b00;
        tick();
        push("load_done_drops", 128'd0);
        push("load_done_pulses", 128'd1);
        push("load_beats", 128'd128);
        e = exp_q.pop_front(); checks++;
        if (128'(init_done) !== e.val) begin errors++; $display("FAIL %s got=%b exp=%0d", e.name, init_done, e.val); end
        e = exp_q.pop_front(); checks++;
        if (128'(pulses) !== e.val) begin errors++; $display("FAIL %s got=%0d exp=%0d", e.name, pulses, e.val); end
        e = exp_q.pop_front(); checks++;
        if (128'(k) !== e.val) begin errors++; $display("FAIL %s got=%0d exp=%0d", e.name, k, e.val); end
        for (int m = 0; m < 128; m++) ref_mem[m] = 128'(m);
        for (int b = 0; b < 128; b += 6) begin
            for (int i = 0; i < 6; i++) begin
                a = 7'((b + i) % 128);
                rd_addr[i*7 +: 7] = a;
                push($sformatf("load_rd%0d_a%0d", i, a), ref_mem[a]);
            end
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); checks++;
                if (rd_data[i*128 +: 128] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[i*128 +: 128], e.val); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_load();
        int n, pulses;
        logic [6:0] a;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            init_valid = 1'b1;
            init_data = 128'hF00 + 128'(k);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_start = 1'b1;
        push("midload_rst_outputs", 128'h0);
        e = exp_q.pop_front(); checks++;
        if ({rf_ready, init_ready, init_done, wr_conflict} !== e.val[3:0]) begin
            errors++; $display("FAIL %s got=%b exp=%b", e.name, {rf_ready, init_ready, init_done, wr_conflict}, e.val[3:0]);
        end
        n = 0; pulses = 0;
        while (rf_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (init_done === 1'b1) pulses++;
        end
        init_start = 1'b0; init_valid = 1'b0;
        push("midload_clear_cycles", 128'd128);
        push("midload_no_done", 128'd0);
        e = exp_q.pop_front(); checks++;
        if (128'(n) !== e.val) begin errors++; $display("FAIL %s got=%0d exp=%0d", e.name, n, e.val); end
        e = exp_q.pop_front(); checks++;
        if (128'(pulses) !== e.val) begin errors++; $display("FAIL %s got=%0d exp=%0d", e.name, pulses, e.val); end
        for (int m = 0; m < 128; m++) ref_mem[m] = '0;
        for (int b = 0; b < 128; b += 6) begin
            for (int i = 0; i < 6; i++) begin
                a = 7'((b + i) % 128);
                rd_addr[i*7 +: 7] = a;
                push($sformatf("midload_rd%0d_a%0d", i, a), ref_mem[a]);
            end
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); checks++;
                if (rd_data[i*128 +: 128] !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data[i*128 +: 128], e.val); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_ports();
        test_small_nobypass();
        test_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spu_regfile_mp.md
Name: spu_regfile_mp

Overview:
- Parametrised multi-port register file for the SPU datapath.
- Generalises the fixed 128x128, 6-read/2-write register file:
  - configurable width, depth and read/write port counts
  - deterministic write-port priority
  - optional combinational write-to-read bypass
- Replaces the wide parallel preload bus with:
  - a sequenced post-reset clear
  - a streamed valid/ready initialisation load
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 128, bits per register
- DEPTH, 128, number of registers (power of 2, ≥2)
- ADDR_W, 7, address width; must equal log2(DEPTH)
- NUM_RD, 6, read ports
- NUM_WR, 2, write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see array only

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses, port j in slice j
- wr_data  in  NUM_WR*DATA_W  write data, port j in slice j
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i in slice i
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- init_start  in  1  request streamed load of all DEPTH registers
- init_valid  in  1  init_data valid
- init_data  in  DATA_W  load beat data
- init_ready  out  1  block accepts a load beat
- init_done  out  1  one-cycle pulse after last load beat
- rf_ready  out  1  array usable by wr/rd ports (IDLE)
- wr_conflict  out  1  registered pulse: ≥2 enabled write ports hit the same address

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- FSM states: CLEAR, IDLE, LOAD. Entry counter cnt is ADDR_W+1 bits.

Reset:
- Any edge with rst=1 sets: state=CLEAR, cnt=0, rf_ready=0, init_ready=0, init_done=0, wr_conflict=0.
- Array contents are not touched on the reset edge itself.
- Reset aborts any state, including mid-LOAD.

CLEAR:
- Each edge with rst=0 writes 0 to entry cnt, then cnt++.
- The edge that clears entry DEPTH-1 moves to IDLE; rf_ready=1 from that edge.
- Clear takes exactly DEPTH cycles after rst deasserts.
- wr_en is ignored. init_start is ignored.

IDLE:
- Write ports:
  - On the edge, for each j with wr_en[j]=1: array[wr_addr[j]] <= wr_data[j].
  - Same-address collision: highest-index port wins.
  - wr_conflict=1 next cycle if any two enabled ports share an address, else 0.
- Reads:
  - rd_data[i] = array[rd_addr[i]], combinational, zero latency.
  - If BYPASS=1 and some enabled port j has wr_addr[j]==rd_addr[i], rd_data[i]=wr_data[j] instead, using the highest such j.
  - If BYPASS=0, new data becomes visible the cycle after the write edge.
- init_start=1:
  - Writes in the same cycle still complete.
  - Next state LOAD: cnt=0, rf_ready=0, init_ready=1.

LOAD:
- Each edge with init_valid & init_ready writes init_data to entry cnt, then cnt++.
- init_valid=0 stalls; cnt holds.
- Beat DEPTH-1 moves to IDLE: init_ready=0, rf_ready=1, init_done=1 for exactly one cycle.
- wr_en ignored. init_start ignored. wr_conflict held at 0.

Reads outside IDLE:
- In CLEAR and LOAD, reads return raw array contents with no bypass.
- Data may be partially cleared or loaded.

Outputs:
- Only rd_data is combinational; all other outputs are registered.

Test Plan:
- Release rst, count cycles → rf_ready rises exactly DEPTH=128 cycles later; all 6 read ports return 0 for addresses 0, 64, 127.
- IDLE: wr_en=2'b11, both addr 5, data A/B; rd_addr[0]=5 → rd_data[0]=B same cycle (BYPASS=1); array[5]=B; wr_conflict=1 next cycle only.
- BYPASS=0 build: write 0xDEAD to reg 3 while reading 3 → old value that cycle, 0xDEAD next cycle.
- init_start, stream 128 beats with data=index, init_valid low every 3rd cycle → init_done pulses once after beat 127; reg k reads k; wr_en writes during LOAD have no effect.
- Assert rst at beat 40 of LOAD → CLEAR restarts; after 128 cycles all registers read 0; init_done never pulses.
- Reduced config DATA_W=32, DEPTH=16, NUM_RD=3, NUM_WR=3: ports 0 and 2 write addr 15 → port 2 data stored; clear takes 16 cycles.
